// File: rtl/if_stage.sv
// if_stage: instruction fetch PC and imem read handshake feeding the IF/ID register.
module if_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter logic [31:0] NOP_INSN     = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rd_data,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d, pc_q, pc_d, pend_q, pend_d, buf_pc_q, buf_pc_d;
    logic [31:0] insn_q, insn_d, buf_insn_q, buf_insn_d;
    logic        en_q, en_d, squash_q, squash_d;
    logic        brk, redir;
    logic [29:0] target;

    assign brk       = br_taken & en_q & ~stall;
    assign redir     = flush | brk;
    assign target    = flush ? new_pc : br_addr;
    assign imem_req  = (state_q == FETCH) & ~reset;
    assign imem_addr = addr_q;
    assign if_pc     = pc_q;
    assign if_insn   = insn_q;
    assign if_en     = en_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        insn_d     = insn_q;
        en_d       = en_q;
        squash_d   = squash_q;
        pend_d     = pend_q;
        buf_pc_d   = buf_pc_q;
        buf_insn_d = buf_insn_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                addr_d  = redir ? target : addr_q;
            end
            FETCH: begin
                if (imem_rdy) begin
                    if (squash_q || redir) begin
                        // Squashed or redirected data is dropped; a fresh redirect beats the pending one.
                        squash_d = 1'b0;
                        addr_d   = redir ? target : pend_q;
                        en_d     = redir ? 1'b0 : en_q;
                        insn_d   = redir ? NOP_INSN : insn_q;
                    end else if (!stall) begin
                        insn_d = imem_rd_data;
                        pc_d   = addr_q;
                        en_d   = 1'b1;
                        addr_d = addr_q + 30'd1;
                    end else begin
                        buf_insn_d = imem_rd_data;
                        buf_pc_d   = addr_q;
                        addr_d     = addr_q + 30'd1;
                        state_d    = HOLD;
                    end
                end else if (redir) begin
                    // Address must stay stable until rdy, so remember the target instead.
                    en_d     = 1'b0;
                    insn_d   = NOP_INSN;
                    pend_d   = target;
                    squash_d = 1'b1;
                end else if (!stall) begin
                    en_d = 1'b0;
                end
            end
            HOLD: begin
                if (redir) begin
                    addr_d  = target;
                    en_d    = 1'b0;
                    insn_d  = NOP_INSN;
                    state_d = FETCH;
                end else if (!stall) begin
                    insn_d  = buf_insn_q;
                    pc_d    = buf_pc_q;
                    en_d    = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= RESET_VECTOR;
            pc_q       <= 30'h0;
            insn_q     <= NOP_INSN;
            en_q       <= 1'b0;
            squash_q   <= 1'b0;
            pend_q     <= 30'h0;
            buf_pc_q   <= 30'h0;
            buf_insn_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
            en_q       <= en_d;
            squash_q   <= squash_d;
            pend_q     <= pend_d;
            buf_pc_q   <= buf_pc_d;
            buf_insn_q <= buf_insn_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage against a wait-state imem model.
module tb_if_stage;
    logic        clk, reset, stall, flush, br_taken, imem_req, imem_rdy, if_en;
    logic [29:0] new_pc, br_addr, imem_addr, if_pc;
    logic [31:0] imem_rd_data, if_insn;
    logic [93:0] e;
    int          vec, miss, wait_n, wcnt;

    if_stage #(.RESET_VECTOR(30'h0), .NOP_INSN(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rd_data(imem_rd_data), .if_pc(if_pc), .if_insn(if_insn),
        .if_en(if_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after wait_n wait states; the returned word equals its address.
    assign imem_rdy     = imem_req && (wcnt == wait_n);
    assign imem_rd_data = {2'b00, imem_addr};
    always @(posedge clk) wcnt <= (reset || !imem_req || imem_rdy) ? 0 : wcnt + 1;

    function automatic logic [93:0] obs();
        return {imem_req, imem_addr, if_en, if_pc, if_insn};
    endfunction

    function automatic logic [93:0] pk(input logic r, input logic [29:0] a, input logic en,
                                       input logic [29:0] p, input logic [31:0] n);
        return {r, a, en, p, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        e = pk(1'b0, 30'h0, 1'b0, 30'h0, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL reset: got %h exp %h", obs(), e); end
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        step();
        e = pk(1'b1, 30'h0, 1'b0, 30'h0, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL zw_first: got %h exp %h", obs(), e); end
        for (int i = 0; i < 4; i++) begin
            step();
            e = pk(1'b1, 30'(i + 1), 1'b1, 30'(i), 32'(i));
            vec++; if (obs() !== e) begin miss++; $display("FAIL zw%0d: got %h exp %h", i, obs(), e); end
        end
    endtask

    task automatic test_stall();
        step();
        e = pk(1'b1, 30'h5, 1'b1, 30'h4, 32'h4);
        vec++; if (obs() !== e) begin miss++; $display("FAIL pre_stall: got %h exp %h", obs(), e); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            e = pk(1'b0, 30'h6, 1'b1, 30'h4, 32'h4);
            vec++; if (obs() !== e) begin miss++; $display("FAIL hold%0d: got %h exp %h", i, obs(), e); end
        end
        stall = 1'b0;
        step();
        e = pk(1'b1, 30'h6, 1'b1, 30'h5, 32'h5);
        vec++; if (obs() !== e) begin miss++; $display("FAIL release: got %h exp %h", obs(), e); end
        step();
        e = pk(1'b1, 30'h7, 1'b1, 30'h6, 32'h6);
        vec++; if (obs() !== e) begin miss++; $display("FAIL post_stall: got %h exp %h", obs(), e); end
    endtask

    task automatic test_branch();
        wait_n = 2;
        br_taken = 1'b1;
        br_addr = 30'h100;
        step();
        e = pk(1'b1, 30'h7, 1'b0, 30'h6, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL brk_bubble: got %h exp %h", obs(), e); end
        br_addr = 30'h200;
        step();
        br_taken = 1'b0;
        e = pk(1'b1, 30'h7, 1'b0, 30'h6, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL brk_wait: got %h exp %h", obs(), e); end
        step();
        e = pk(1'b1, 30'h100, 1'b0, 30'h6, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL brk_target: got %h exp %h", obs(), e); end
        step();
        step();
        step();
        e = pk(1'b1, 30'h101, 1'b1, 30'h100, 32'h100);
        vec++; if (obs() !== e) begin miss++; $display("FAIL brk_first: got %h exp %h", obs(), e); end
    endtask

    task automatic test_wait_states();
        for (int i = 1; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
                step();
                e = pk(1'b1, 30'(32'h100 + i), 1'b0, 30'(32'h100 + i - 1), 32'h100 + i - 1);
                vec++; if (obs() !== e) begin miss++; $display("FAIL ws%0d_%0d: got %h exp %h", i, j, obs(), e); end
            end
            step();
            e = pk(1'b1, 30'(32'h101 + i), 1'b1, 30'(32'h100 + i), 32'h100 + i);
            vec++; if (obs() !== e) begin miss++; $display("FAIL ws%0d_v: got %h exp %h", i, obs(), e); end
        end
    endtask

    task automatic test_flush_priority();
        wait_n = 0;
        flush = 1'b1; new_pc = 30'h40; br_taken = 1'b1; br_addr = 30'h80; stall = 1'b1;
        step();
        flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
        e = pk(1'b1, 30'h40, 1'b0, 30'h103, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL prio_redir: got %h exp %h", obs(), e); end
        step();
        e = pk(1'b1, 30'h41, 1'b1, 30'h40, 32'h40);
        vec++; if (obs() !== e) begin miss++; $display("FAIL prio_first: got %h exp %h", obs(), e); end
    endtask

    task automatic test_flush_hold();
        stall = 1'b1;
        step();
        e = pk(1'b0, 30'h42, 1'b1, 30'h40, 32'h40);
        vec++; if (obs() !== e) begin miss++; $display("FAIL fh_hold: got %h exp %h", obs(), e); end
        flush = 1'b1; new_pc = 30'h20;
        step();
        flush = 1'b0; stall = 1'b0;
        e = pk(1'b1, 30'h20, 1'b0, 30'h40, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL fh_redir: got %h exp %h", obs(), e); end
        step();
        e = pk(1'b1, 30'h21, 1'b1, 30'h20, 32'h20);
        vec++; if (obs() !== e) begin miss++; $display("FAIL fh_first: got %h exp %h", obs(), e); end
    endtask

    task automatic test_reset_mid();
        flush = 1'b1; new_pc = 30'h9;
        step();
        flush = 1'b0; wait_n = 2;
        step();
        e = pk(1'b1, 30'h9, 1'b0, 30'h20, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL rm_wait: got %h exp %h", obs(), e); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        e = pk(1'b0, 30'h0, 1'b0, 30'h0, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL rm_reset: got %h exp %h", obs(), e); end
        wait_n = 0;
        step();
        e = pk(1'b1, 30'h0, 1'b0, 30'h0, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL rm_fetch: got %h exp %h", obs(), e); end
        step();
        e = pk(1'b1, 30'h1, 1'b1, 30'h0, 32'h0);
        vec++; if (obs() !== e) begin miss++; $display("FAIL rm_first: got %h exp %h", obs(), e); end
    endtask

    initial begin
        vec = 0; miss = 0; wait_n = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = 30'h0; br_addr = 30'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch();
        test_wait_states();
        test_flush_priority();
        test_flush_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
